// File: rtl/lemming_ctrl.sv
// Lemming walker FSM: walk/dig/fall/splat with a saturating fall-duration counter.
// All outputs decode registered state only.
module lemming_ctrl #(
   parameter int FALL_LIMIT = 20,
   parameter int CNT_W      = 6
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             bump_left,
   input  logic             bump_right,
   input  logic             ground,
   input  logic             dig,
   output logic             walk_left,
   output logic             walk_right,
   output logic             aaah,
   output logic             digging,
   output logic             splat,
   output logic [CNT_W-1:0] fall_cycles
);

   typedef enum logic [2:0] {WL, WR, FL, FR, DL, DR, SPLAT} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(FALL_LIMIT);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [CNT_W-1:0] cnt_inc;

   // Counter holds at all-ones so a very long fall can never wrap into survival.
   assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;

   always_ff @(posedge clk) begin
      if (areset) begin
         state_reg <= WL;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = '0;
      case (state_reg)
         WL: begin
            if (!ground)        state_next = FL;
            else if (dig)       state_next = DL;
            else if (bump_left) state_next = WR;
         end
         WR: begin
            if (!ground)         state_next = FR;
            else if (dig)        state_next = DR;
            else if (bump_right) state_next = WL;
         end
         DL: if (!ground) state_next = FL;
         DR: if (!ground) state_next = FR;
         FL: begin
            if (!ground) cnt_next = cnt_inc;
            else         state_next = (cnt_reg >= LIMIT) ? SPLAT : WL;
         end
         FR: begin
            if (!ground) cnt_next = cnt_inc;
            else         state_next = (cnt_reg >= LIMIT) ? SPLAT : WR;
         end
         SPLAT: state_next = SPLAT;
         default: state_next = WL;
      endcase
   end

   assign walk_left   = (state_reg == WL);
   assign walk_right  = (state_reg == WR);
   assign aaah        = (state_reg == FL) || (state_reg == FR);
   assign digging     = (state_reg == DL) || (state_reg == DR);
   assign splat       = (state_reg == SPLAT);
   assign fall_cycles = cnt_reg;

endmodule

// File: tb/tb_lemming_ctrl.sv
// Directed bench for lemming_ctrl: walks, digs, falls at the survival boundary,
// counter saturation, splat absorption and reset overrides.
module tb_lemming_ctrl;

   localparam int FALL_LIMIT = 20;
   localparam int CNT_W      = 6;

   localparam logic [4:0] O_WL    = 5'b10000;
   localparam logic [4:0] O_WR    = 5'b01000;
   localparam logic [4:0] O_FALL  = 5'b00100;
   localparam logic [4:0] O_DIG   = 5'b00010;
   localparam logic [4:0] O_SPLAT = 5'b00001;

   logic             clk = 1'b0;
   logic             areset, bump_left, bump_right, ground, dig;
   logic             walk_left, walk_right, aaah, digging, splat;
   logic [CNT_W-1:0] fall_cycles;

   int n_checks = 0;
   int n_fail   = 0;

   lemming_ctrl #(.FALL_LIMIT(FALL_LIMIT), .CNT_W(CNT_W)) dut (
      .clk(clk), .areset(areset),
      .bump_left(bump_left), .bump_right(bump_right),
      .ground(ground), .dig(dig),
      .walk_left(walk_left), .walk_right(walk_right),
      .aaah(aaah), .digging(digging), .splat(splat),
      .fall_cycles(fall_cycles)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [4:0] exp_oh, input int exp_cnt);
      logic [4:0]       obs_oh;
      logic [CNT_W-1:0] exp_c;
      obs_oh = {walk_left, walk_right, aaah, digging, splat};
      exp_c  = CNT_W'(exp_cnt);
      n_checks++;
      assert (obs_oh === exp_oh)
      else begin
         n_fail++;
         $error("FAIL %s outputs: observed %b expected %b", tag, obs_oh, exp_oh);
      end
      n_checks++;
      assert (fall_cycles === exp_c)
      else begin
         n_fail++;
         $error("FAIL %s fall_cycles: observed %0d expected %0d", tag, fall_cycles, exp_c);
      end
      $display("step %-14s outputs=%b fall_cycles=%0d", tag, obs_oh, fall_cycles);
   endtask

   initial begin
      areset = 1'b1; ground = 1'b1; dig = 1'b0; bump_left = 1'b0; bump_right = 1'b0;
      step(); chk("reset", O_WL, 0);
      areset = 1'b0;
      step(); chk("wl_idle", O_WL, 0);

      // Bumps: only the current-direction bump turns
      bump_right = 1'b1; step(); chk("wl_ign_br", O_WL, 0);
      bump_right = 1'b0; bump_left = 1'b1; step(); chk("wl_bl", O_WR, 0);
      step(); chk("wr_ign_bl", O_WR, 0);
      bump_left = 1'b0; bump_right = 1'b1; step(); chk("wr_br", O_WL, 0);
      bump_left = 1'b1; step(); chk("wl_both", O_WR, 0);
      step(); chk("wr_both", O_WL, 0);
      bump_left = 1'b0; bump_right = 1'b0;

      // Fall beats dig and bump; short fall keeps direction left
      ground = 1'b0; dig = 1'b1; bump_left = 1'b1;
      step(); chk("wl_fall_pri", O_FALL, 0);
      dig = 1'b0; bump_left = 1'b0;
      step(); chk("fl_c1", O_FALL, 1);
      step(); chk("fl_c2", O_FALL, 2);
      ground = 1'b1; step(); chk("fl_land", O_WL, 0);

      // Dig in WR, bumps ignored, fall, land right
      bump_left = 1'b1; step(); chk("to_wr", O_WR, 0);
      bump_left = 1'b0; dig = 1'b1; step(); chk("wr_dig", O_DIG, 0);
      dig = 1'b0; bump_left = 1'b1; bump_right = 1'b1; step(); chk("dr_ign_bump", O_DIG, 0);
      bump_left = 1'b0; bump_right = 1'b0; dig = 1'b1; step(); chk("dr_ign_dig", O_DIG, 0);
      dig = 1'b0; ground = 1'b0; step(); chk("dr_fall", O_FALL, 0);
      ground = 1'b1; step(); chk("fr_land", O_WR, 0);

      // Dig in WL, land left
      bump_right = 1'b1; step(); chk("to_wl", O_WL, 0);
      bump_right = 1'b0; dig = 1'b1; step(); chk("wl_dig", O_DIG, 0);
      dig = 1'b0; ground = 1'b0; step(); chk("dl_fall", O_FALL, 0);
      ground = 1'b1; step(); chk("fl_land2", O_WL, 0);

      // Survival boundary: 20 low edges survive
      ground = 1'b0;
      for (int i = 0; i < FALL_LIMIT; i++) begin
         step(); chk("fall20", O_FALL, i);
      end
      ground = 1'b1; step(); chk("land20", O_WL, 0);

      // 21 low edges splat, then splat is absorbing
      ground = 1'b0;
      for (int i = 0; i < FALL_LIMIT + 1; i++) begin
         step(); chk("fall21", O_FALL, i);
      end
      ground = 1'b1; step(); chk("land21", O_SPLAT, 0);
      for (int i = 0; i < 8; i++) begin
         ground     = 1'($urandom_range(0, 1));
         dig        = 1'($urandom_range(0, 1));
         bump_left  = 1'($urandom_range(0, 1));
         bump_right = 1'($urandom_range(0, 1));
         step(); chk("splat_hold", O_SPLAT, 0);
      end
      ground = 1'b1; dig = 1'b0; bump_left = 1'b0; bump_right = 1'b0;
      areset = 1'b1; step(); chk("rst_splat", O_WL, 0);
      areset = 1'b0;

      // Long fall saturates at 63
      ground = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step(); chk("fall100", O_FALL, (i > 63) ? 63 : i);
      end
      ground = 1'b1; step(); chk("land100", O_SPLAT, 0);
      areset = 1'b1; step(); chk("rst_splat2", O_WL, 0);
      areset = 1'b0;

      // Reset mid-fall at count 10, ground still low during reset
      ground = 1'b0;
      for (int i = 0; i < 11; i++) begin
         step(); chk("fall_mid", O_FALL, i);
      end
      areset = 1'b1; step(); chk("rst_midfall", O_WL, 0);
      step(); chk("rst_hold", O_WL, 0);
      areset = 1'b0; step(); chk("post_rst_fall", O_FALL, 0);
      ground = 1'b1; step(); chk("post_rst_land", O_WL, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
